// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiplier sequencer.
// Holds the sequencer state enum, the datapath widths, the partial-product
// shift amounts and a helper that zero-extends an operand half to the
// multiplier width.
package mul_pkg;

  localparam int MUL_W  = 16;
  localparam int HALF_W = 8;

  // Shift amounts applied to partial products when accumulating the
  // 32-bit wide result.
  localparam int SH_LO  = 0;
  localparam int SH_MID = 8;
  localparam int SH_HI  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NARROW = 3'd1,
    W0     = 3'd2,
    W1     = 3'd3,
    W2     = 3'd4,
    W3     = 3'd5,
    DONE   = 3'd6
  } mul_state_t;

  // Zero-extend an 8-bit operand half so it can drive the 16-bit multiplier.
  function automatic logic [MUL_W-1:0] zext_half(input logic [HALF_W-1:0] h);
    return {{(MUL_W-HALF_W){1'b0}}, h};
  endfunction

endpackage

// File: rtl/multiplier.sv
// multiplier: combinational 16x16 multiplier returning the low 16 bits.
// Ports:
//   rs_data  in  16  first operand
//   rd_data  in  16  second operand
//   product  out 16  (rs_data * rd_data) mod 2^16
module multiplier
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] rs_data,
  input  logic [MUL_W-1:0] rd_data,
  output logic [MUL_W-1:0] product
);

  assign product = rs_data * rd_data;

endmodule

// File: rtl/mul_sched.sv
// mul_sched: shares one 16-bit combinational multiplier between two
// requesters. A round-robin arbiter in IDLE accepts one request, the
// operands are latched, and the result is produced either in one narrow
// pass (truncated 16-bit product) or in four 8x8 passes that build the full
// 32-bit product in an accumulator. The result is held on a single
// valid/ready response channel tagged with the requester ID.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req{0,1}_valid/ready        request handshake (ready is combinational)
//   req{0,1}_a / _b             operands (a -> rs_data, b -> rd_data)
//   req{0,1}_wide               1 = full 32-bit product
//   resp_valid/ready            response handshake
//   resp_data, resp_id          product and owning requester
//   busy                        sequencer is not idle
module mul_sched
  import mul_pkg::*;
#(
  parameter bit WIDE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [MUL_W-1:0] req0_a,
  input  logic [MUL_W-1:0] req0_b,
  input  logic             req0_wide,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [MUL_W-1:0] req1_a,
  input  logic [MUL_W-1:0] req1_b,
  input  logic             req1_wide,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_id,
  output logic             busy
);

  mul_state_t       state;
  mul_state_t       next_state;
  logic [MUL_W-1:0] a_q;
  logic [MUL_W-1:0] b_q;
  logic             id_q;
  logic             wide_q;
  logic             last_id;
  logic [31:0]      acc;
  logic [31:0]      acc_next;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             wide_sel;
  logic [MUL_W-1:0] mul_a;
  logic [MUL_W-1:0] mul_b;
  logic [MUL_W-1:0] p;
  logic [31:0]      p_ext;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_id) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Ready is gated by rst_n so both readies read 0 while reset is asserted.
  assign accept     = (state == IDLE) && (grant0 || grant1);
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign wide_sel   = (grant0 ? req0_wide : req1_wide) && WIDE_EN;

  // Next-state sequencing through the narrow or four-pass wide path.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = wide_sel ? W0 : NARROW;
        end else begin
          next_state = IDLE;
        end
      end
      NARROW:  next_state = DONE;
      W0:      next_state = W1;
      W1:      next_state = W2;
      W2:      next_state = W3;
      W3:      next_state = DONE;
      DONE: begin
        if (resp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand select: full latched operands for NARROW, 8-bit halves per wide pass.
  always_comb begin
    mul_a = {MUL_W{1'b0}};
    mul_b = {MUL_W{1'b0}};
    case (state)
      NARROW: begin
        mul_a = a_q;
        mul_b = b_q;
      end
      W0: begin
        mul_a = zext_half(a_q[HALF_W-1:0]);
        mul_b = zext_half(b_q[HALF_W-1:0]);
      end
      W1: begin
        mul_a = zext_half(a_q[HALF_W-1:0]);
        mul_b = zext_half(b_q[MUL_W-1:HALF_W]);
      end
      W2: begin
        mul_a = zext_half(a_q[MUL_W-1:HALF_W]);
        mul_b = zext_half(b_q[HALF_W-1:0]);
      end
      W3: begin
        mul_a = zext_half(a_q[MUL_W-1:HALF_W]);
        mul_b = zext_half(b_q[MUL_W-1:HALF_W]);
      end
      default: begin
        mul_a = {MUL_W{1'b0}};
        mul_b = {MUL_W{1'b0}};
      end
    endcase
  end

  multiplier u_mul (
    .rs_data (mul_a),
    .rd_data (mul_b),
    .product (p)
  );

  assign p_ext = {16'h0000, p};

  // Accumulate partial products; 8x8 partials are exact in 16 bits so no carry is lost.
  always_comb begin
    acc_next = acc;
    case (state)
      W0:      acc_next = p_ext << SH_LO;
      W1:      acc_next = acc + (p_ext << SH_MID);
      W2:      acc_next = acc + (p_ext << SH_MID);
      W3:      acc_next = acc + (p_ext << SH_HI);
      default: acc_next = acc;
    endcase
  end

  // Sequencer state, latched request, accumulator and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= {MUL_W{1'b0}};
      b_q        <= {MUL_W{1'b0}};
      id_q       <= 1'b0;
      wide_q     <= 1'b0;
      last_id    <= 1'b1;
      acc        <= 32'h0000_0000;
      resp_data  <= 32'h0000_0000;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      acc        <= acc_next;
      resp_valid <= (next_state == DONE);
      busy       <= (next_state != IDLE);
      if (accept) begin
        a_q     <= grant0 ? req0_a : req1_a;
        b_q     <= grant0 ? req0_b : req1_b;
        id_q    <= grant1;
        wide_q  <= wide_sel;
        last_id <= grant1;
      end
      // Final pass of either path loads the held result.
      if ((state == NARROW) || (state == W3)) begin
        resp_data <= wide_q ? acc_next : p_ext;
        resp_id   <= id_q;
      end
    end
  end

endmodule
